layer_sequencer: RTL and testbench

//  Hardware sequencer for the Eyeriss core: holds a table of per-layer descriptors and

---
 rtl/layer_sequencer_pkg.sv | 29 ++
 rtl/layer_sequencer_desc_table.sv | 28 ++
 rtl/layer_sequencer.sv | 155 +++++++++++++++
 tb/tb_layer_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer: descriptor layout and FSM state encoding.
package layer_sequencer_pkg;

    typedef struct packed {
        logic [7:0] ifmap_h;
        logic [3:0] filt_r;
        logic [7:0] ofmap_e;
        logic [9:0] in_ch_c;
        logic [9:0] out_ch_m;
        logic [2:0] stride_u;
        logic [3:0] pass_p;
    } layer_desc_t;

    localparam int unsigned DESC_W = $bits(layer_desc_t);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_GAP0   = 4'd1,
        S_RST    = 4'd2,
        S_SCAN   = 4'd3,
        S_LOAD   = 4'd4,
        S_ISSUE  = 4'd5,
        S_LAUNCH = 4'd6,
        S_RUN    = 4'd7,
        S_GAP    = 4'd8,
        S_FIN    = 4'd9
    } seq_state_e;

endpackage

// File: rtl/layer_sequencer_desc_table.sv
// Per-layer descriptor storage: one write port, one registered read port.
module layer_desc_table
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 8,
    localparam int unsigned LIDX_W = $clog2(NUM_LAYERS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LIDX_W-1:0] wr_addr,
    input  logic [DESC_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [LIDX_W-1:0] rd_addr,
    output logic [DESC_W-1:0] rd_data
);

    logic [DESC_W-1:0] mem [NUM_LAYERS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Runs a masked subset of stored layer descriptors back to back on the core.
// Optional LAYER_PERF_EN adds a per-layer RUN cycle counter (perf_cycles/perf_valid).
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 8,
    parameter int unsigned RST_CYCLES = 1,
    parameter int unsigned GAP_CYCLES = 1,
    localparam int unsigned LIDX_W = $clog2(NUM_LAYERS)
) (
    input  logic                  core_clk,
    input  logic                  core_reset,
    input  logic                  tbl_wr_en,
    input  logic [LIDX_W-1:0]     tbl_wr_addr,
    input  logic [DESC_W-1:0]     tbl_wr_data,
    input  logic [NUM_LAYERS-1:0] layer_mask,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [LIDX_W-1:0]     layer_idx,
    output logic                  acc_soft_reset,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [DESC_W-1:0]     desc_data,
    output logic                  layer_start,
    input  logic                  layer_done
`ifdef LAYER_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic                  perf_valid
`endif
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned PTR_W   = LIDX_W + 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NUM_LAYERS);

    seq_state_e            state;
    logic [NUM_LAYERS-1:0] mask_r;
    logic [PTR_W-1:0]      ptr;
    logic [CNT_W-1:0]      cnt;
    logic [LIDX_W-1:0]     layer_idx_r;
    logic [DESC_W-1:0]     tbl_rd_data;

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state       <= S_IDLE;
            mask_r      <= '0;
            ptr         <= '0;
            cnt         <= '0;
            layer_idx_r <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mask_r <= layer_mask;
                    ptr    <= '0;
                    cnt    <= '0;
                    state  <= (GAP_CYCLES > 0) ? S_GAP0 : S_RST;
                end
                S_GAP0: if (cnt == GAP_LAST) begin
                    cnt   <= '0;
                    state <= S_RST;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_RST: if (cnt == RST_LAST) begin
                    cnt   <= '0;
                    state <= S_SCAN;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_SCAN: if (ptr >= PTR_END) begin
                    state <= S_FIN;
                end else if (mask_r[ptr[LIDX_W-1:0]]) begin
                    state <= S_LOAD;
                end else begin
                    ptr <= ptr + PTR_W'(1);
                end
                S_LOAD: begin
                    layer_idx_r <= ptr[LIDX_W-1:0];
                    state       <= S_ISSUE;
                end
                S_ISSUE:  if (desc_ready) state <= S_LAUNCH;
                S_LAUNCH: state <= S_RUN;
                // With no gap configured the pointer advances directly out of RUN.
                S_RUN: if (layer_done) begin
                    cnt <= '0;
                    if (GAP_CYCLES > 0) begin
                        state <= S_GAP;
                    end else begin
                        ptr   <= ptr + PTR_W'(1);
                        state <= S_SCAN;
                    end
                end
                S_GAP: if (cnt == GAP_LAST) begin
                    cnt   <= '0;
                    ptr   <= ptr + PTR_W'(1);
                    state <= S_SCAN;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    layer_desc_table #(.NUM_LAYERS(NUM_LAYERS)) u_table (
        .clk     (core_clk),
        .wr_en   (tbl_wr_en && !busy),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_en   (state == S_LOAD),
        .rd_addr (ptr[LIDX_W-1:0]),
        .rd_data (tbl_rd_data)
    );

    always_comb begin
        busy           = (state != S_IDLE) && (state != S_FIN);
        done           = (state == S_FIN);
        acc_soft_reset = (state == S_RST);
        desc_valid     = (state == S_ISSUE);
        layer_start    = (state == S_LAUNCH);
        layer_idx      = layer_idx_r;
        desc_data      = (state == S_ISSUE) ? tbl_rd_data : '0;
    end

`ifdef LAYER_PERF_EN
    logic [31:0] perf_cnt;

    // The layer_done cycle itself is counted, so the captured value is cnt+1.
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            perf_cnt    <= '0;
            perf_cycles <= '0;
            perf_valid  <= 1'b0;
        end else begin
            perf_valid <= 1'b0;
            if (state == S_LAUNCH) begin
                perf_cnt <= '0;
            end else if (state == S_RUN) begin
                if (perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
                if (layer_done) begin
                    perf_cycles <= (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;
                    perf_valid  <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed self-checking bench for layer_sequencer (NUM_LAYERS=8, RST_CYCLES=1, GAP_CYCLES=1).
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    logic              core_clk = 1'b0;
    logic              core_reset;
    logic              tbl_wr_en;
    logic [2:0]        tbl_wr_addr;
    logic [DESC_W-1:0] tbl_wr_data;
    logic [7:0]        layer_mask;
    logic              start;
    logic              busy;
    logic              done;
    logic [2:0]        layer_idx;
    logic              acc_soft_reset;
    logic              desc_valid;
    logic              desc_ready;
    logic [DESC_W-1:0] desc_data;
    logic              layer_start;
    logic              layer_done;
`ifdef LAYER_PERF_EN
    logic [31:0]       perf_cycles;
    logic              perf_valid;
`endif

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [DESC_W-1:0] shadow [8];

    always #5 core_clk = ~core_clk;

    layer_sequencer #(.NUM_LAYERS(8), .RST_CYCLES(1), .GAP_CYCLES(1)) dut (
        .core_clk       (core_clk),
        .core_reset     (core_reset),
        .tbl_wr_en      (tbl_wr_en),
        .tbl_wr_addr    (tbl_wr_addr),
        .tbl_wr_data    (tbl_wr_data),
        .layer_mask     (layer_mask),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .layer_idx      (layer_idx),
        .acc_soft_reset (acc_soft_reset),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_data      (desc_data),
        .layer_start    (layer_start),
        .layer_done     (layer_done)
`ifdef LAYER_PERF_EN
        ,
        .perf_cycles    (perf_cycles),
        .perf_valid     (perf_valid)
`endif
    );

    typedef struct {
        string      name;
        logic [7:0] mask;
        int         d;          // cycles from launch to layer_done
        int         hold;       // ISSUE cycles with desc_ready held low
        int         exp_launch;
        int         exp_edges;  // clock edges from start to done visible
        int         inj_at;     // cycle to inject start + table write while busy (0 = none)
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic write_entry(input int i, input logic [DESC_W-1:0] data);
        @(negedge core_clk);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 3'(i);
        tbl_wr_data = data;
        @(negedge core_clk);
        tbl_wr_en   = 1'b0;
    endtask

    // Timing per run with GAP=RST=1: 3 edges into SCAN, 9 SCAN cycles, plus
    // LOAD + ISSUE(hold+1) + LAUNCH + RUN(d) + GAP per launched layer.
    task automatic run_case(input vec_t v);
        int k = 0, launches = 0, rst_cyc = 0, rem = 0, exp_pos = 0;
        int hold_left, issue_cyc = 0, perf_pulses = 0;
        logic [31:0] last_perf = '0;
        logic [DESC_W-1:0] first_data = '0;
        bit stable_ok = 1'b1;
        bit done_seen = 1'b0;
        hold_left = v.hold;
        @(negedge core_clk);
        layer_mask = v.mask;
        start      = 1'b1;
        desc_ready = 1'b1;
        layer_done = 1'b0;
        while (!done_seen && k < 3000) begin
            @(negedge core_clk);
            k++;
            start     = 1'b0;
            tbl_wr_en = 1'b0;
            if (k == 1) chk({v.name, "_busy_on"}, 64'(busy), 64'd1);
            if (acc_soft_reset) rst_cyc++;
            layer_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) layer_done = 1'b1;
            end
            if (layer_start) begin
                launches++;
                while (exp_pos < 8 && !v.mask[exp_pos]) exp_pos++;
                chk({v.name, "_launch_idx"}, 64'(layer_idx), 64'(exp_pos));
                chk({v.name, "_issue_len"}, 64'(issue_cyc), 64'(v.hold + 1));
                exp_pos++;
                rem       = v.d;
                hold_left = v.hold;
                issue_cyc = 0;
                stable_ok = 1'b1;
            end
            if (desc_valid) begin
                issue_cyc++;
                if (issue_cyc == 1) first_data = desc_data;
                else if (desc_data !== first_data) stable_ok = 1'b0;
                if (hold_left > 0) begin
                    hold_left--;
                    desc_ready = 1'b0;
                end else begin
                    chk({v.name, "_desc_data"}, 64'(desc_data), 64'(shadow[layer_idx]));
                    chk({v.name, "_desc_stable"}, 64'(stable_ok), 64'd1);
                    desc_ready = 1'b1;
                end
            end else begin
                desc_ready = 1'b1;
            end
`ifdef LAYER_PERF_EN
            if (perf_valid) begin
                perf_pulses++;
                last_perf = perf_cycles;
            end
`endif
            if (done) begin
                done_seen = 1'b1;
                chk({v.name, "_done_edges"}, 64'(k), 64'(v.exp_edges));
                chk({v.name, "_busy_at_done"}, 64'(busy), 64'd0);
            end
            if (k == v.inj_at) begin
                start       = 1'b1;
                layer_mask  = 8'hFF;
                tbl_wr_en   = 1'b1;
                tbl_wr_addr = 3'd7;
                tbl_wr_data = '1;
            end
        end
        if (!done_seen) chk({v.name, "_done_timeout"}, 64'd0, 64'd1);
        layer_mask = 8'h00;
        layer_done = 1'b0;
        @(negedge core_clk);
        chk({v.name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        chk({v.name, "_launches"}, 64'(launches), 64'(v.exp_launch));
        chk({v.name, "_rst_cycles"}, 64'(rst_cyc), 64'd1);
`ifdef LAYER_PERF_EN
        chk({v.name, "_perf_pulses"}, 64'(perf_pulses), 64'(v.exp_launch));
        if (launches > 0) chk({v.name, "_perf_cycles"}, 64'(last_perf), 64'(v.d));
`endif
    endtask

    initial begin
        layer_desc_t e;
        int k;
        bit saw_idx2, saw_done;
        int rem, after;

        vecs[0] = '{"one_layer",   8'h10, 1, 0,  1, 17, 0};
        vecs[1] = '{"all_layers",  8'hFF, 5, 0,  8, 84, 0};
        vecs[2] = '{"empty_mask",  8'h00, 1, 0,  0, 12, 0};
        vecs[3] = '{"ready_stall", 8'h04, 2, 10, 1, 28, 0};
        vecs[4] = '{"busy_inject", 8'h81, 3, 0,  2, 26, 5};
        vecs[5] = '{"perf7",       8'h08, 7, 0,  1, 23, 0};

        core_reset  = 1'b1;
        tbl_wr_en   = 1'b0;
        tbl_wr_addr = '0;
        tbl_wr_data = '0;
        layer_mask  = '0;
        start       = 1'b0;
        desc_ready  = 1'b0;
        layer_done  = 1'b0;
        repeat (3) @(negedge core_clk);
        chk("reset_outputs", {busy, done, layer_idx, acc_soft_reset, desc_valid, layer_start, desc_data},
            64'd0);
        core_reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e.ifmap_h  = 8'(i * 13 + 5);
            e.filt_r   = 4'(i + 1);
            e.ofmap_e  = 8'(200 - i * 7);
            e.in_ch_c  = 10'(i * 97 + 3);
            e.out_ch_m = 10'(1000 - i * 33);
            e.stride_u = 3'(i);
            e.pass_p   = 4'(15 - i);
            shadow[i]  = e;
            write_entry(i, e);
        end

        // Stray layer_done / desc_ready while idle
        layer_done = 1'b1;
        desc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            chk("idle_stray", {61'd0, busy, done, layer_start}, 64'd0);
        end
        layer_done = 1'b0;

        foreach (vecs[i]) run_case(vecs[i]);

        // Reset during RUN of layer 2 with mask 0F
        saw_idx2 = 1'b0;
        saw_done = 1'b0;
        rem   = 0;
        after = 0;
        k     = 0;
        @(negedge core_clk);
        layer_mask = 8'h0F;
        start      = 1'b1;
        desc_ready = 1'b1;
        while (after < 3 && k < 500) begin
            @(negedge core_clk);
            k++;
            start = 1'b0;
            layer_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) layer_done = 1'b1;
            end
            if (layer_start) begin
                rem = 5;
                if (layer_idx == 3'd2) saw_idx2 = 1'b1;
            end
            if (saw_idx2) after++;
        end
        chk("midrun_reached_layer2", 64'(saw_idx2), 64'd1);
        core_reset = 1'b1;
        layer_done = 1'b0;
        @(negedge core_clk);
        core_reset = 1'b0;
        chk("midrun_reset_outputs", {busy, done, layer_idx, acc_soft_reset, desc_valid, layer_start, desc_data},
            64'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge core_clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrun_no_done", 64'(saw_done), 64'd0);

        run_case('{"rerun_0F", 8'h0F, 2, 0, 4, 36, 0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
